// File: rtl/wave_seq_ctrl_if.sv
// Host-side signal bundle for wave_seq_ctrl: table write port, burst control
// and waveform/status outputs. The master drives controls; the slave is the sequencer.
interface wave_seq_ctrl_if #(
  parameter int N     = 4,
  parameter int DEPTH = 4,
  parameter int RW    = 4
);
  localparam int AW = $clog2(DEPTH);

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [N-1:0]  wr_on;
  logic [N-1:0]  wr_off;
  logic [AW:0]   len;
  logic [RW-1:0] repeats;
  logic          start;
  logic          stop;
  logic          s_wave;
  logic          busy;
  logic          done;
  logic [AW-1:0] seg_idx;

  modport master (
    output wr_en, wr_addr, wr_on, wr_off, len, repeats, start, stop,
    input  s_wave, busy, done, seg_idx
  );

  modport slave (
    input  wr_en, wr_addr, wr_on, wr_off, len, repeats, start, stop,
    output s_wave, busy, done, seg_idx
  );
endinterface

// File: rtl/wave_seq_ctrl.sv
// Programmable square-wave sequencer: plays a table of (on, off) durations a set
// number of passes. Define WAVE_SEQ_LOOP_EN to make repeats == 0 loop until stop.
module wave_seq_ctrl #(
  parameter int N     = 4,
  parameter int DEPTH = 4,
  parameter int RW    = 4
) (
  input  logic            clk,
  input  logic            reset,
  wave_seq_ctrl_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   LEN_MAX = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ONE_L   = 1;
  localparam logic [AW-1:0] ONE_AW  = 1;
  localparam logic [N-1:0]  ONE_N   = 1;
  localparam logic [RW-1:0] ONE_RW  = 1;

  typedef enum logic [1:0] {IDLE, ON_PH, OFF_PH} state_t;

  state_t        r_state;
  logic [N-1:0]  r_on  [DEPTH];
  logic [N-1:0]  r_off [DEPTH];
  logic [N-1:0]  r_cnt;
  logic [RW-1:0] r_pass;
  logic [RW-1:0] r_rep;
  logic [AW:0]   r_len;
  logic [AW-1:0] r_seg;
  logic          r_wave;
  logic          r_busy;
  logic          r_done;

  logic [N-1:0]  w_cur_on;
  logic [N-1:0]  w_cur_off;
  logic          w_ph_end;
  logic          w_last_seg;
  logic          w_finish;
  logic [AW-1:0] w_adv_idx;
  logic          w_adv_on_nz;
  logic [RW-1:0] w_pass_nxt;
  logic [AW:0]   w_len_eff;
  logic          w_wr_ok;
  logic          w_rep_ok;
  logic          w_start_ok;

  always_comb begin
    w_cur_on   = r_on[r_seg];
    w_cur_off  = r_off[r_seg];
    // A zero off duration still occupies one OFF_PH cycle (all-zero entry).
    if (r_state == ON_PH)
      w_ph_end = (r_cnt == w_cur_on - ONE_N);
    else
      w_ph_end = (w_cur_off == '0) || (r_cnt == w_cur_off - ONE_N);
    w_last_seg  = ({1'b0, r_seg} >= r_len - ONE_L);
    w_pass_nxt  = r_pass + ONE_RW;
    w_finish    = w_last_seg && (r_rep != '0) && (w_pass_nxt == r_rep);
    w_adv_idx   = w_last_seg ? '0 : r_seg + ONE_AW;
    w_adv_on_nz = (r_on[w_adv_idx] != '0);
    w_len_eff   = (bus.len > LEN_MAX) ? LEN_MAX : bus.len;
    w_wr_ok     = ({1'b0, bus.wr_addr} < LEN_MAX);
`ifdef WAVE_SEQ_LOOP_EN
    w_rep_ok    = 1'b1;
`else
    w_rep_ok    = (bus.repeats != '0);
`endif
    w_start_ok  = bus.start && !bus.stop && (bus.len != '0) && w_rep_ok;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_on[i]  <= '0;
        r_off[i] <= '0;
      end
    end else if (r_state == IDLE && bus.wr_en && w_wr_ok) begin
      r_on[bus.wr_addr]  <= bus.wr_on;
      r_off[bus.wr_addr] <= bus.wr_off;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_pass  <= '0;
      r_rep   <= '0;
      r_len   <= '0;
      r_seg   <= '0;
      r_wave  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start_ok) begin
            r_len  <= w_len_eff;
            r_rep  <= bus.repeats;
            r_seg  <= '0;
            r_pass <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b1;
            if (r_on[0] != '0) begin
              r_state <= ON_PH;
              r_wave  <= 1'b1;
            end else begin
              r_state <= OFF_PH;
              r_wave  <= 1'b0;
            end
          end
        end
        default: begin
          if (bus.stop) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_wave  <= 1'b0;
            r_seg   <= '0;
            r_cnt   <= '0;
          end else if (!w_ph_end) begin
            r_cnt <= r_cnt + ONE_N;
          end else begin
            r_cnt <= '0;
            if (r_state == ON_PH && w_cur_off != '0) begin
              r_state <= OFF_PH;
              r_wave  <= 1'b0;
            end else if (w_finish) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
              r_wave  <= 1'b0;
              r_seg   <= '0;
              r_pass  <= w_pass_nxt;
              r_done  <= 1'b1;
            end else begin
              r_seg <= w_adv_idx;
              if (w_last_seg)
                r_pass <= w_pass_nxt;
              r_state <= w_adv_on_nz ? ON_PH : OFF_PH;
              r_wave  <= w_adv_on_nz;
            end
          end
        end
      endcase
    end
  end

  assign bus.s_wave  = r_wave;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.seg_idx = r_seg;
endmodule

// File: tb/tb_wave_seq_ctrl.sv
// Self-checking bench for wave_seq_ctrl: directed vector table, hand-written
// corner sequences and randomized bursts against a phase-list reference model.
module tb_wave_seq_ctrl;
  localparam int N     = 4;
  localparam int DEPTH = 4;
  localparam int RW    = 4;

  logic clk;
  logic reset;

  wave_seq_ctrl_if #(.N(N), .DEPTH(DEPTH), .RW(RW)) bus ();

  wave_seq_ctrl #(.N(N), .DEPTH(DEPTH), .RW(RW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] ons;
    logic [15:0] offs;
    int          lenv;
    int          repv;
    logic [31:0] pat;
    int          nb;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;
  int m_on  [DEPTH];
  int m_off [DEPTH];
  bit q_wave [$];
  int q_seg  [$];

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected per-cycle (wave, seg) list built by expanding the table into phases.
  task automatic build_model(input int lenv, input int repv);
    int l;
    l = (lenv > DEPTH) ? DEPTH : lenv;
    q_wave.delete();
    q_seg.delete();
    for (int p = 0; p < repv; p++)
      for (int e = 0; e < l; e++) begin
        if (m_on[e] == 0 && m_off[e] == 0) begin
          q_wave.push_back(1'b0); q_seg.push_back(e);
        end else begin
          for (int c = 0; c < m_on[e]; c++) begin
            q_wave.push_back(1'b1); q_seg.push_back(e);
          end
          for (int c = 0; c < m_off[e]; c++) begin
            q_wave.push_back(1'b0); q_seg.push_back(e);
          end
        end
      end
  endtask

  task automatic write_entry(input int a, input int on, input int off);
    @(negedge clk);
    bus.wr_en = 1'b1; bus.wr_addr = a[1:0]; bus.wr_on = on[3:0]; bus.wr_off = off[3:0];
    @(negedge clk);
    bus.wr_en = 1'b0;
    m_on[a] = on; m_off[a] = off;
  endtask

  task automatic load_vec(input vec_t v);
    for (int e = 0; e < DEPTH; e++)
      write_entry(e, int'(v.ons[4*e +: 4]), int'(v.offs[4*e +: 4]));
  endtask

  task automatic run_burst(input int lenv, input int repv, input logic [31:0] pat,
                           input int nb, input bit inject);
    build_model(lenv, repv);
    @(negedge clk);
    bus.len = lenv[2:0]; bus.repeats = repv[3:0]; bus.start = 1'b1;
    for (int i = 0; i < q_wave.size(); i++) begin
      @(negedge clk);
      bus.start = 1'b0; bus.wr_en = 1'b0;
      chk("wave", int'(bus.s_wave), int'(q_wave[i]));
      chk("busy", int'(bus.busy), 1);
      chk("seg_idx", int'(bus.seg_idx), q_seg[i]);
      chk("done_early", int'(bus.done), 0);
      if (i < nb) chk("pattern", int'(bus.s_wave), int'(pat[nb-1-i]));
      if (inject && i == 1) begin
        bus.wr_en = 1'b1; bus.wr_addr = 2'd0; bus.wr_on = 4'd7; bus.wr_off = 4'd7;
        bus.start = 1'b1; bus.len = 3'd1; bus.repeats = 4'd1;
      end
    end
    @(negedge clk);
    chk("done", int'(bus.done), 1);
    chk("busy_end", int'(bus.busy), 0);
    chk("wave_end", int'(bus.s_wave), 0);
    chk("seg_end", int'(bus.seg_idx), 0);
    @(negedge clk);
    chk("done_pulse", int'(bus.done), 0);
  endtask

  vec_t vecs [4];

  initial begin
    vecs[0] = '{ons: 16'h0013, offs: 16'h0042, lenv: 2, repv: 2, pat: 32'b11100100001110010000, nb: 20};
    vecs[1] = '{ons: 16'h0020, offs: 16'h0002, lenv: 3, repv: 1, pat: 32'b00110, nb: 5};
    vecs[2] = '{ons: 16'h0111, offs: 16'h1011, lenv: 7, repv: 1, pat: 32'b101010, nb: 6};
    vecs[3] = '{ons: 16'h0002, offs: 16'h0001, lenv: 1, repv: 3, pat: 32'b110110110, nb: 9};

    reset = 1'b1;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_on = '0; bus.wr_off = '0;
    bus.len = '0; bus.repeats = '0; bus.start = 1'b0; bus.stop = 1'b0;
    for (int e = 0; e < DEPTH; e++) begin m_on[e] = 0; m_off[e] = 0; end
    #12;
    chk("rst_wave", int'(bus.s_wave), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_seg", int'(bus.seg_idx), 0);
    @(negedge clk);
    reset = 1'b0;

    for (int k = 0; k < 4; k++) begin
      load_vec(vecs[k]);
      run_burst(vecs[k].lenv, vecs[k].repv, vecs[k].pat, vecs[k].nb, 1'b0);
    end

    // Writes and start while busy must be ignored; table then replays unchanged.
    load_vec(vecs[0]);
    run_burst(2, 1, 32'b1110010000, 10, 1'b1);
    run_burst(1, 1, 32'b11100, 5, 1'b0);

    // Stop at cycle 4 of the basic burst.
    @(negedge clk);
    bus.len = 3'd2; bus.repeats = 4'd2; bus.start = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      chk("stop_pre_wave", int'(bus.s_wave), (c <= 3) ? 1 : 0);
      chk("stop_pre_busy", int'(bus.busy), 1);
    end
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    chk("stop_wave", int'(bus.s_wave), 0);
    chk("stop_busy", int'(bus.busy), 0);
    chk("stop_seg", int'(bus.seg_idx), 0);
    chk("stop_done", int'(bus.done), 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("stop_no_done", int'(bus.done), 0);
      chk("stop_idle", int'(bus.busy), 0);
    end

    // start+stop together in IDLE, and len == 0, both leave the block idle.
    bus.start = 1'b1; bus.stop = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.stop = 1'b0;
    chk("startstop_busy", int'(bus.busy), 0);
    bus.len = 3'd0; bus.repeats = 4'd1; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("len0_busy", int'(bus.busy), 0);

    // Back-to-back: start accepted in the done cycle.
    write_entry(0, 1, 1);
    @(negedge clk);
    bus.len = 3'd1; bus.repeats = 4'd1; bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    chk("b2b_c1_wave", int'(bus.s_wave), 1);
    @(negedge clk);
    chk("b2b_c2_wave", int'(bus.s_wave), 0);
    @(negedge clk);
    chk("b2b_done", int'(bus.done), 1);
    bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    chk("b2b_restart_busy", int'(bus.busy), 1);
    chk("b2b_restart_wave", int'(bus.s_wave), 1);
    chk("b2b_restart_done", int'(bus.done), 0);
    @(negedge clk);
    chk("b2b_c5_wave", int'(bus.s_wave), 0);
    @(negedge clk);
    chk("b2b_done2", int'(bus.done), 1);

    // Loop mode (or its rejection when the feature is compiled out).
    load_vec(vecs[0]);
    build_model(2, 1);
    @(negedge clk);
    bus.len = 3'd2; bus.repeats = 4'd0; bus.start = 1'b1;
`ifdef WAVE_SEQ_LOOP_EN
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      chk("loop_wave", int'(bus.s_wave), int'(q_wave[i % q_wave.size()]));
      chk("loop_busy", int'(bus.busy), 1);
      chk("loop_done", int'(bus.done), 0);
    end
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    chk("loop_stop_busy", int'(bus.busy), 0);
`else
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      chk("rep0_busy", int'(bus.busy), 0);
    end
`endif

    // Randomized bursts.
    for (int r = 0; r < 20; r++) begin
      for (int e = 0; e < DEPTH; e++) begin
        int on, off;
        on  = ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 3));
        off = int'($urandom_range(0, 3));
        write_entry(e, on, off);
      end
      run_burst(int'($urandom_range(1, 7)), int'($urandom_range(1, 3)), 32'd0, 0, 1'b0);
    end

    // Asynchronous reset mid-burst clears outputs at once and empties the table.
    load_vec(vecs[0]);
    @(negedge clk);
    bus.len = 3'd2; bus.repeats = 4'd2; bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_wave", int'(bus.s_wave), 0);
    chk("async_rst_busy", int'(bus.busy), 0);
    chk("async_rst_done", int'(bus.done), 0);
    chk("async_rst_seg", int'(bus.seg_idx), 0);
    @(negedge clk);
    reset = 1'b0;
    for (int e = 0; e < DEPTH; e++) begin m_on[e] = 0; m_off[e] = 0; end
    run_burst(4, 1, 32'b0000, 4, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
